// File: rtl/c7bbiu_rd_arb_rr_pkg.sv
// Shared AXI encodings and client ID constants for the c7b BIU read path.
package c7bbiu_rd_arb_rr_pkg;

    localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [2:0] AXI_SIZE_DWORD = 3'b011;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [3:0] AXI_CACHE_DEV_NB = 4'b0000;
    localparam logic [2:0] AXI_PROT_DATA    = 3'b000;

    localparam int AXI_RID_LSU = 0;
    localparam int AXI_RID_IFU = 1;
    localparam int AXI_RID_ICU = 2;

endpackage

// File: rtl/c7bbiu_rr_pick.sv
// Combinational one-hot picker: first eligible client at or after i_ptr, wrapping.
// Tying i_ptr to zero gives lowest-index-wins fixed priority.
module c7bbiu_rr_pick
    import c7bbiu_rd_arb_rr_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && (i == (int'(i_ptr) + k) % NREQ) && i_elig[i]) begin
                    o_gnt[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/c7bbiu_rd_arb_rr.sv
// AXI read-address arbiter with per-client outstanding-read limits.
// Define C7BBIU_RD_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 highest).
module c7bbiu_rd_arb_rr
    import c7bbiu_rd_arb_rr_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AW        = 32,
    parameter int IDW       = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NREQ-1:0]     i_req_val,
    output logic [NREQ-1:0]     o_req_ack,
    input  logic [NREQ*AW-1:0]  i_req_addr,
    input  logic [NREQ*8-1:0]   i_req_len,
    input  logic [NREQ*2-1:0]   i_req_burst,
    output logic                o_ar_valid,
    input  logic                i_ar_ready,
    output logic [IDW-1:0]      o_ar_id,
    output logic [AW-1:0]       o_ar_addr,
    output logic [7:0]          o_ar_len,
    output logic [2:0]          o_ar_size,
    output logic [1:0]          o_ar_burst,
    output logic                o_ar_lock,
    output logic [3:0]          o_ar_cache,
    output logic [2:0]          o_ar_prot,
    input  logic                i_r_valid,
    input  logic                i_r_ready,
    input  logic                i_r_last,
    input  logic [IDW-1:0]      i_r_id,
    output logic [NREQ-1:0]     o_outst_full
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_OUTST);

    logic            r_ar_valid;
    logic [IDW-1:0]  r_ar_id;
    logic [AW-1:0]   r_ar_addr;
    logic [7:0]      r_ar_len;
    logic [2:0]      r_ar_size;
    logic [1:0]      r_ar_burst;
    logic [CW-1:0]   r_cnt [NREQ];
    logic [CW-1:0]   w_cnt_nxt [NREQ];
    logic [NREQ-1:0] r_full;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_ack;
    logic [NREQ-1:0] w_dec;
    logic            w_free;
    logic [PW-1:0]   w_ptr;
    logic [IDW-1:0]  w_win;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_len;
    logic [1:0]      w_burst;

    // AR handshake: a beat moves when o_ar_valid & i_ar_ready at a rising edge;
    // the holding register may reload in that same cycle, and the beat is stable until then.
    assign w_free = ~r_ar_valid | i_ar_ready;
    assign w_elig = i_req_val & ~r_full;
    assign w_ack  = (w_free & ~i_reset) ? w_gnt : '0;

    c7bbiu_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_elig (w_elig),
        .i_ptr  (w_ptr),
        .o_gnt  (w_gnt)
    );

`ifdef C7BBIU_RD_ARB_RR_EN
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ack[i]) w_ptr_nxt = PW'((i + 1) % NREQ);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_ptr <= '0;
        else         r_ptr <= w_ptr_nxt;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_comb begin
        w_win   = '0;
        w_addr  = '0;
        w_len   = '0;
        w_burst = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_ack[i]) begin
                w_win   = IDW'(i);
                w_addr  = i_req_addr[i*AW +: AW];
                w_len   = i_req_len[i*8 +: 8];
                w_burst = i_req_burst[i*2 +: 2];
            end
        end
    end

    // A same-cycle grant and retire cancel; a retire at zero holds the count at zero.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_dec[i]     = i_r_valid & i_r_ready & i_r_last & (i_r_id == IDW'(i));
            w_cnt_nxt[i] = r_cnt[i];
            if (w_ack[i] & ~w_dec[i])
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            else if (w_dec[i] & ~w_ack[i] & (r_cnt[i] != '0))
                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ar_valid <= 1'b0;
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_full     <= '0;
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else begin
            if (w_free) begin
                r_ar_valid <= |w_ack;
                if (|w_ack) begin
                    r_ar_id    <= w_win;
                    r_ar_addr  <= w_addr;
                    r_ar_len   <= w_len;
                    r_ar_size  <= AXI_SIZE_DWORD;
                    r_ar_burst <= w_burst;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i]  <= w_cnt_nxt[i];
                r_full[i] <= (w_cnt_nxt[i] == LIMIT);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!i_reset)
                assert (!(w_dec[i] && !w_ack[i] && (r_cnt[i] == '0)))
                else $error("c7bbiu_rd_arb_rr: outstanding underflow on client %0d", i);
        end
    end
`endif

    assign o_req_ack    = w_ack;
    assign o_ar_valid   = r_ar_valid;
    assign o_ar_id      = r_ar_id;
    assign o_ar_addr    = r_ar_addr;
    assign o_ar_len     = r_ar_len;
    assign o_ar_size    = r_ar_size;
    assign o_ar_burst   = r_ar_burst;
    assign o_ar_lock    = 1'b0;
    assign o_ar_cache   = AXI_CACHE_DEV_NB;
    assign o_ar_prot    = AXI_PROT_DATA;
    assign o_outst_full = r_full;

endmodule

// File: doc/c7bbiu_rd_arb_rr.md
# c7bbiu_rd_arb_rr

Parametrised AXI read-address arbiter for the c7b bus interface unit, successor to the fixed three-client read arbiter. It accepts read requests from `NREQ` clients (IFU, LSU, ICU, and future clients such as a prefetcher), picks one per cycle by rotating or fixed priority, and drives a registered AXI AR channel. It also counts outstanding reads per client from R-channel last beats and blocks any client that reaches its outstanding limit.

## Interface
- `NREQ`, 3: number of requesting clients; client index = AXI ARID.
- `AW`, 32: address width.
- `IDW`, 4: AXI ID width; requires `NREQ <= 2**IDW`.
- `MAX_OUTST`, 2: maximum outstanding reads per client, at least 1.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_val` in NREQ: per-client read request.
- `req_ack` out NREQ: one-hot grant; request accepted this cycle.
- `req_addr` in NREQ*AW: per-client address; client i occupies `[i*AW +: AW]`.
- `req_len` in NREQ*8: per-client AXI burst length (beats minus 1).
- `req_burst` in NREQ*2: per-client AXI burst type.
- `ar_valid` out 1, `ar_ready` in 1: AXI AR handshake.
- `ar_id` out IDW, `ar_addr` out AW, `ar_len` out 8, `ar_size` out 3, `ar_burst` out 2, `ar_lock` out 1, `ar_cache` out 4, `ar_prot` out 3: AXI AR payload.
- `r_valid` in 1, `r_ready` in 1, `r_last` in 1, `r_id` in IDW: R channel, monitored only.
- `outst_full` out NREQ: client i is at `MAX_OUTST`.

## Operation
- The holding register holds one AR beat. It is free when `~ar_valid | ar_ready`.
- A client is eligible when `req_val[i]` is high and `~outst_full[i]`.
- When the holding register is free and at least one client is eligible, the winner gets `req_ack[winner]=1` in the same cycle. Its payload loads into the holding register at the next edge.
- Payload fields:
  - `ar_id` = winner index, zero-extended.
  - `ar_size` = doubleword.
  - `ar_lock` = 0, `ar_cache` = 0, `ar_prot` = 0.
- `ar_valid` and the payload stay stable until `ar_ready` is sampled high (AXI rule). Back-to-back grants can load a new beat in the cycle the current one drains.
- Outstanding counter per client, width `$clog2(MAX_OUTST+1)`:
  - Increments on `req_ack[i]`.
  - Decrements on `r_valid & r_ready & r_last & (r_id == i)`.
  - If both happen in the same cycle, the counter is unchanged.
  - `r_id >= NREQ` is ignored.
  - Counter underflow (decrement at 0) is a protocol error: the counter holds at 0, and a simulation assertion fires.
- `outst_full[i]` = (counter == `MAX_OUTST`), registered.
- Reset mid-operation clears the holding register and all counters immediately. R beats from before reset are discarded by the system, not by this block.

## Timing
- Reset values: `ar_valid=0`, AR payload all zeros, `req_ack=0`, `outst_full=0`, all counters 0, round-robin pointer 0.
- `req_ack` is combinational from `req_val`, `outst_full`, `ar_valid`, `ar_ready` and the pointer. There is no combinational path from `r_*` to `req_ack`.
- Latency: a request acked in cycle N gives `ar_valid=1` in cycle N+1.
- Sustained throughput: one AR per cycle while `ar_ready=1`.
- While `ar_valid & ~ar_ready`, `req_ack` is all zeros.
- When the counter reaches `MAX_OUTST`, the client is masked from the following cycle. It can be granted again the cycle after its last beat is retired.

## Configuration
- `C7BBIU_RD_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at the pointer and wraps modulo `NREQ`.
  - After a grant to client i, the pointer becomes `(i+1) mod NREQ`.
  - The pointer does not change in cycles without a grant.
- `C7BBIU_RD_ARB_RR_EN` undefined: fixed priority, lowest index wins (LSU index 0). The pointer logic is not built.

## Structure
- Shared `axi_types` package/include holds:
  - AXI size, burst, cache and prot encodings.
  - Client ID constants (`AXI_RID_LSU=0`, `AXI_RID_IFU=1`, `AXI_RID_ICU=2`).
- Sub-module `c7bbiu_rr_pick`: parametrised `NREQ`-wide picker, combinational.
  - Inputs: eligibility vector and start pointer.
  - Output: one-hot grant.
  - With start pointer tied to 0 it is the fixed-priority picker.

## Test plan
- Test 1, single client:
  - Stimulus: reset, then client 1 requests addr `0x0000_1000`, len 3, INCR, with `ar_ready=1`.
  - Required response: `req_ack=3'b010` in cycle N; in N+1 `ar_valid=1`, `ar_id=1`, `ar_addr=0x1000`, `ar_len=3`, `ar_burst=01`.
- Test 2, back-pressure:
  - Stimulus: `ar_ready=0` for 4 cycles with a pending beat.
  - Required response: payload stable, `req_ack=0`; the beat transfers on the first cycle with `ar_ready=1`.
- Test 3, round-robin (RR_EN defined):
  - Stimulus: all three clients request continuously.
  - Required response: grants go 0,1,2,0,1,2.
  - With RR_EN undefined: grants go 0,0,0.
- Test 4, outstanding limit:
  - Stimulus: `MAX_OUTST=2`, client 2 is acked twice.
  - Required response: `outst_full[2]=1` and further `req_val[2]` is not acked.
  - Then `r_last` with `r_id=2` clears `outst_full` and the next request is acked.
- Test 5, simultaneous events:
  - Stimulus: ack and `r_last` for the same client in one cycle.
  - Required response: the counter is unchanged.
- Test 6, reset mid-operation:
  - Stimulus: assert `reset` while `ar_valid=1` and the counters are nonzero.
  - Required response: all outputs return to reset values asynchronously.
